multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multicycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back. Drives the datapath mux selects and write enables, and supplies the 2-bit `alu_op` consumed by the ALU control (00 add, 01 sub, 10 decode funct). Memory accesses stall on a `mem_ready` handshake.

## Interface
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `opcode`  in  6  instruction[31:26] from IR; sampled only in DECODE
- `mem_ready`  in  1  memory completes the current access this cycle
- `pc_write`, `pc_write_cond`, `ir_write`  out  1 each  PC / conditional-PC / IR write enables
- `i_or_d`  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- `mem_read`, `mem_write`  out  1 each  memory request strobes
- `mem_to_reg`  out  1  1 = MDR to register file, 0 = ALUOut
- `reg_write`  out  1  register file write enable
- `reg_dst`  out  1  1 = rd, 0 = rt
- `alu_src_a`  out  1  0 = PC, 1 = A
- `alu_src_b`  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- `alu_op`  out  2  to ALU control
- `pc_source`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `instr_done`  out  1  one-cycle pulse in the last cycle of every instruction
- `illegal_op`  out  1  one-cycle pulse on unsupported opcode
- `state`  out  4  current state encoding, for debug and bench

## Operation
- State encodings:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5
  - EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11
  - Codes 12-15 are unreachable; if entered, the next state is FETCH.
- Outputs are a combinational decode of `state`. Exceptions: the strobes qualified by `mem_ready` or `opcode`, as listed below. Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write = pc_write = mem_ready.
  - Transition: mem_ready → DECODE, else stay.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state by opcode:
    - 100011 (lw) or 101011 (sw) → MEM_ADDR
    - 000000 → EXECUTE
    - 000100 → BRANCH
    - 000010 → JUMP
    - 001000 → ADDI_EX
    - anything else → FETCH, with illegal_op=1 and instr_done=1
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Transition: lw → MEM_READ; sw → MEM_WRITE. Opcode is held stable by IR.
- MEM_READ:
  - Outputs: mem_read=1, i_or_d=1.
  - Transition: mem_ready → MEM_WB, else stay.
- MEM_WB:
  - Outputs: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1.
  - Transition: → FETCH.
- MEM_WRITE:
  - Outputs: mem_write=1, i_or_d=1, instr_done=mem_ready.
  - Transition: mem_ready → FETCH, else stay.
- EXECUTE:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=10.
  - Transition: → R_WB.
- R_WB:
  - Outputs: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1.
  - Transition: → FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1.
  - Transition: → FETCH.
- JUMP:
  - Outputs: pc_write=1, pc_source=10, instr_done=1.
  - Transition: → FETCH.
- ADDI_EX:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Transition: → ADDI_WB.
- ADDI_WB:
  - Outputs: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1.
  - Transition: → FETCH.
- Memory handshake:
  - mem_read and mem_write are held high for every stall cycle.
  - Write enables never fire while mem_ready=0.

## Timing
- Reset:
  - With rst=1 at a rising edge, state becomes FETCH.
  - While rst=1, every output is forced to 0, including `state`.
  - Reset wins over any transition, including mid-stall in MEM_READ or MEM_WRITE.
- First cycle after reset release: FETCH with mem_read=1.
- Cycles per instruction with mem_ready tied high:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j: 3
  - illegal opcode: 2
- Each cycle that mem_ready is low in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- mem_ready outside those three states is ignored.
- instr_done is high for exactly one cycle per instruction; the next cycle is FETCH.

## Test plan
- R-type: rst then release, mem_ready=1, opcode=000000 → state 0,1,6,7,0.
  - ir_write=pc_write=1 in cycle 1.
  - alu_op=10 in cycle 3.
  - reg_write=1 and reg_dst=1 in cycle 4, with instr_done pulse.
- lw with stalls: mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_READ → 10 total cycles.
  - ir_write pulses once.
  - mem_read stays high through the stalls.
  - mem_to_reg=1 and reg_write=1 only in the MEM_WB cycle.
- sw then beq back to back → states 0,1,2,5,0,1,8,0.
  - mem_write is high only in state 5.
  - In state 8: pc_write_cond=1, alu_op=01, pc_source=01.
- j, then addi → states 0,1,9,0,1,10,11,0.
  - pc_source=10 with pc_write=1 in JUMP.
  - alu_src_b=10 and alu_op=00 in ADDI_EX.
- Illegal opcode 111111 → DECODE asserts illegal_op=1 and instr_done=1 for one cycle; next state is FETCH; no write enable fires.
- Reset mid-instruction: assert rst during a MEM_READ stall → next state is FETCH; all outputs are 0 while rst is high; no reg_write or mem_write occurs.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: fetch/decode/execute/memory/write-back
// sequencing with a mem_ready stall handshake on every memory access.
module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t state_r;
    state_t next_state;

    // Next-state selection; unreachable encodings fall back to FETCH.
    always_comb begin
        next_state = S_FETCH;
        case (state_r)
            S_FETCH:     next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEM_ADDR;
                    OP_RTYPE:     next_state = S_EXECUTE;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
                    OP_ADDI:      next_state = S_ADDI_EX;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  next_state = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  next_state = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    next_state = S_FETCH;
            S_MEM_WRITE: next_state = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   next_state = S_R_WB;
            S_R_WB:      next_state = S_FETCH;
            S_BRANCH:    next_state = S_FETCH;
            S_JUMP:      next_state = S_FETCH;
            S_ADDI_EX:   next_state = S_ADDI_WB;
            S_ADDI_WB:   next_state = S_FETCH;
            default:     next_state = S_FETCH;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state;
        end
    end

    // Output decode of the current state; everything reads 0 while rst is high.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        state         = 4'd0;
        if (rst) begin
            state = 4'd0;
        end else begin
            state = state_r;
            case (state_r)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: begin
                            illegal_op = 1'b0;
                        end
                        default: begin
                            illegal_op = 1'b1;
                            instr_done = 1'b1;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_R_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    instr_done    = 1'b1;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    instr_done = 1'b1;
                end
                S_ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_ADDI_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                default: begin
                    pc_write = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class, stalls,
// an illegal opcode and a reset during a memory stall, against hand-computed values.
module tb_multicycle_control;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
    logic       mem_to_reg, reg_write, reg_dst, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, illegal_op;
    logic [3:0] state;
    logic [21:0] all_outs;

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .reg_dst(reg_dst),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
        .state(state)
    );

    assign all_outs = {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
                       mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
                       pc_source, instr_done, illegal_op, state};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock, then apply this cycle's inputs and let outputs settle.
    task automatic cyc(input logic rs, input logic mr);
        @(posedge clk);
        #1;
        rst       = rs;
        mem_ready = mr;
        #1;
    endtask

    int  lw_st [10] = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4};
    bit  lw_mr [10] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
    bit  lw_rd [10] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 0};
    bit  lw_ir [10] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    bit  lw_wb [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b1;
        opcode    = 6'b000000;

        // Reset: everything including state reads 0.
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        check("rst_outs", 32'(all_outs), 32'd0);

        // R-type: 0,1,6,7,0
        cyc(1'b0, 1'b1);
        check("r_st0", 32'(state), 32'd0);
        check("r_fetch_we", 32'({ir_write, pc_write, mem_read, alu_src_b}), 32'b11101);
        cyc(1'b0, 1'b1);
        check("r_st1", 32'(state), 32'd1);
        check("r_dec_srcb", 32'(alu_src_b), 32'd3);
        cyc(1'b0, 1'b1);
        check("r_st6", 32'(state), 32'd6);
        check("r_ex", 32'({alu_op, alu_src_a, alu_src_b}), 32'b10100);
        cyc(1'b0, 1'b1);
        check("r_st7", 32'(state), 32'd7);
        check("r_wb", 32'({reg_write, reg_dst, mem_to_reg, instr_done}), 32'b1101);

        // lw with 2 FETCH stalls and 3 MEM_READ stalls: 10 cycles.
        opcode = 6'b100011;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, lw_mr[i]);
            check($sformatf("lw_st_%0d", i), 32'(state), 32'(lw_st[i]));
            check($sformatf("lw_rd_%0d", i), 32'(mem_read), 32'(lw_rd[i]));
            check($sformatf("lw_ir_%0d", i), 32'(ir_write), 32'(lw_ir[i]));
            check($sformatf("lw_wb_%0d", i), 32'({reg_write, mem_to_reg, instr_done}),
                  lw_wb[i] ? 32'b111 : 32'b000);
        end
        check("lw_iod", 32'(i_or_d), 32'd0);

        // sw (one MEM_WRITE stall) then beq.
        opcode = 6'b101011;
        cyc(1'b0, 1'b1);
        check("sw_st0", 32'(state), 32'd0);
        cyc(1'b0, 1'b1);
        check("sw_st1", 32'(state), 32'd1);
        cyc(1'b0, 1'b1);
        check("sw_st2", 32'(state), 32'd2);
        check("sw_addr", 32'({alu_src_a, alu_src_b, mem_write}), 32'b1100);
        cyc(1'b0, 1'b0);
        check("sw_stall", 32'({state, mem_write, i_or_d, instr_done}), 32'b0101110);
        cyc(1'b0, 1'b1);
        check("sw_done", 32'({state, mem_write, i_or_d, instr_done}), 32'b0101111);
        opcode = 6'b000100;
        cyc(1'b0, 1'b1);
        check("beq_st0", 32'({state, mem_write}), 32'b00000);
        cyc(1'b0, 1'b1);
        check("beq_st1", 32'(state), 32'd1);
        cyc(1'b0, 1'b1);
        check("beq_st8", 32'(state), 32'd8);
        check("beq_outs", 32'({pc_write_cond, pc_write, alu_op, pc_source, instr_done, alu_src_a}),
              32'b10010111);

        // j then addi.
        cyc(1'b0, 1'b1);
        check("j_st0", 32'(state), 32'd0);
        opcode = 6'b000010;
        cyc(1'b0, 1'b1);
        check("j_st1", 32'(state), 32'd1);
        cyc(1'b0, 1'b1);
        check("j_st9", 32'(state), 32'd9);
        check("j_outs", 32'({pc_write, pc_source, instr_done, pc_write_cond}), 32'b11010);
        cyc(1'b0, 1'b1);
        check("addi_st0", 32'(state), 32'd0);
        opcode = 6'b001000;
        cyc(1'b0, 1'b1);
        check("addi_st1", 32'(state), 32'd1);
        cyc(1'b0, 1'b1);
        check("addi_st10", 32'(state), 32'd10);
        check("addi_ex", 32'({alu_src_a, alu_src_b, alu_op}), 32'b11000);
        cyc(1'b0, 1'b1);
        check("addi_st11", 32'(state), 32'd11);
        check("addi_wb", 32'({reg_write, reg_dst, mem_to_reg, instr_done}), 32'b1001);

        // Illegal opcode; mem_ready low in DECODE must be ignored.
        cyc(1'b0, 1'b1);
        check("ill_st0", 32'(state), 32'd0);
        opcode = 6'b111111;
        cyc(1'b0, 1'b0);
        check("ill_st1", 32'(state), 32'd1);
        check("ill_flags", 32'({illegal_op, instr_done}), 32'b11);
        check("ill_we", 32'({pc_write, pc_write_cond, ir_write, reg_write, mem_write}), 32'd0);
        cyc(1'b0, 1'b1);
        check("ill_next", 32'({state, illegal_op, instr_done}), 32'd0);

        // Reset during a MEM_READ stall.
        opcode = 6'b100011;
        cyc(1'b0, 1'b1);
        check("rmid_st1", 32'(state), 32'd1);
        cyc(1'b0, 1'b1);
        check("rmid_st2", 32'(state), 32'd2);
        cyc(1'b0, 1'b0);
        check("rmid_st3", 32'({state, mem_read}), 32'b00111);
        cyc(1'b1, 1'b0);
        check("rmid_outs0", 32'(all_outs), 32'd0);
        cyc(1'b1, 1'b1);
        check("rmid_outs1", 32'(all_outs), 32'd0);
        cyc(1'b0, 1'b1);
        check("rmid_fetch", 32'({state, mem_read, instr_done, reg_write, mem_write}), 32'b0000_1000);
        cyc(1'b0, 1'b1);
        check("rmid_dec", 32'(state), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
